// File: rtl/prng_pkg.sv
// Shared constants and helpers for the Galois-LFSR stream generator.
// Width-agnostic step function plus the reject-counter sizing rule.
package prng_pkg;

   localparam logic [7:0]  TAPS_8  = 8'hB8;
   localparam logic [15:0] TAPS_16 = 16'hB400;
   localparam logic [31:0] TAPS_32 = 32'h80200003;
   localparam logic [63:0] TAPS_64 = 64'hD800000000000000;

   // Operands are zero-extended to 64 bits; the mask trims back to width.
   function automatic logic [63:0] galois_step(input logic [63:0] s,
                                               input logic [63:0] taps,
                                               input int unsigned width);
      logic [63:0] mask;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return ((s >> 1) ^ (s[0] ? taps : 64'd0)) & mask;
   endfunction

   function automatic int rej_cnt_w(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with step enable, seed load and a stuck-at-zero recovery guard.
// Exposes the next state's low OUT_W bits as the candidate for the stream.
module lfsr_galois
   import prng_pkg::*;
#(
   parameter int                 W     = 8,
   parameter int                 OUT_W = 8,
   parameter logic [W-1:0]       TAPS  = W'(TAPS_8),
   parameter logic [W-1:0]       SEED  = W'(63)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [W-1:0]     load_value,
   output logic [OUT_W-1:0] cand
);

   localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

   logic [W-1:0] state;
   logic [W-1:0] next;

   assign next = W'(galois_step(64'(state), 64'(TAPS), W));
   assign cand = next[OUT_W-1:0];

   // Load wins over the step; a zero state is never allowed to persist.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= SEED_EFF;
      else if (load)
         state <= (load_value != '0) ? load_value : SEED_EFF;
      else if (state == '0)
         state <= SEED_EFF;
      else if (en)
         state <= next;
   end

endmodule

// File: rtl/prng_stream_gen.sv
// Pseudo-random AXI4-Stream source: LFSR candidates filtered by exclusion and
// a runtime upper bound, with registered output and a reject-limit stall flag.
module prng_stream_gen
   import prng_pkg::*;
#(
   parameter int                          LFSR_WIDTH   = 8,
   parameter logic [LFSR_WIDTH-1:0]       TAPS         = LFSR_WIDTH'(TAPS_8),
   parameter logic [LFSR_WIDTH-1:0]       SEED         = LFSR_WIDTH'(63),
   parameter int                          OUTPUT_SIZE  = 8,
   parameter logic [OUTPUT_SIZE-1:0]      EXCLUDE      = OUTPUT_SIZE'(128),
   parameter bit                          EXCLUDE_EN   = 1'b1,
   parameter int                          REJECT_LIMIT = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   seed_valid,
   input  logic [LFSR_WIDTH-1:0]  seed_value,
   input  logic [OUTPUT_SIZE-1:0] bound,
   output logic [OUTPUT_SIZE-1:0] tdata,
   output logic                   tvalid,
   input  logic                   tready,
   output logic                   stalled
);

   localparam int CW = rej_cnt_w(REJECT_LIMIT);

   logic [OUTPUT_SIZE-1:0] cand;
   logic [CW-1:0]          rej_cnt;
   logic                   advance;
   logic                   pass;

   assign advance = !tvalid || tready;
   assign pass    = !(EXCLUDE_EN && cand == EXCLUDE) && (bound == '0 || cand < bound);
   assign stalled = (rej_cnt == CW'(REJECT_LIMIT));

   lfsr_galois #(
      .W     (LFSR_WIDTH),
      .OUT_W (OUTPUT_SIZE),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .en         (advance),
      .load       (seed_valid),
      .load_value (seed_value),
      .cand       (cand)
   );

   // A reseed never retracts a presented beat; otherwise it opens a bubble
   // so the first candidate comes from the new seed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tdata   <= '0;
         tvalid  <= 1'b0;
         rej_cnt <= '0;
      end else if (seed_valid) begin
         rej_cnt <= '0;
         if (advance)
            tvalid <= 1'b0;
      end else if (advance) begin
         if (pass) begin
            tdata   <= cand;
            tvalid  <= 1'b1;
            rej_cnt <= '0;
         end else begin
            tvalid <= 1'b0;
            if (!stalled)
               rej_cnt <= rej_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_prng_stream_gen.sv
// Directed bench for prng_stream_gen: three 8-bit instances with different
// seeds/exclusion settings, table-driven stream checks plus corner sequences.
module tb_prng_stream_gen;

   logic clk;
   logic reset;

   logic       a_seed_valid, b_seed_valid, c_seed_valid;
   logic [7:0] a_seed_value, b_seed_value, c_seed_value;
   logic [7:0] a_bound, b_bound, c_bound;
   logic [7:0] a_tdata, b_tdata, c_tdata;
   logic       a_tvalid, b_tvalid, c_tvalid;
   logic       a_tready, b_tready, c_tready;
   logic       a_stalled, b_stalled, c_stalled;

   int ncmp = 0;
   int nerr = 0;

   // A: SEED=1, no exclusion
   prng_stream_gen #(.SEED(8'd1), .EXCLUDE_EN(1'b0)) dut_a (
      .clk(clk), .reset(reset), .seed_valid(a_seed_valid), .seed_value(a_seed_value),
      .bound(a_bound), .tdata(a_tdata), .tvalid(a_tvalid), .tready(a_tready),
      .stalled(a_stalled));

   // B: SEED=0x71, EXCLUDE=0x80
   prng_stream_gen #(.SEED(8'h71), .EXCLUDE(8'h80), .EXCLUDE_EN(1'b1)) dut_b (
      .clk(clk), .reset(reset), .seed_valid(b_seed_valid), .seed_value(b_seed_value),
      .bound(b_bound), .tdata(b_tdata), .tvalid(b_tvalid), .tready(b_tready),
      .stalled(b_stalled));

   // C: default SEED=63, EXCLUDE=0, REJECT_LIMIT=1024
   prng_stream_gen #(.EXCLUDE(8'h00), .EXCLUDE_EN(1'b1)) dut_c (
      .clk(clk), .reset(reset), .seed_valid(c_seed_valid), .seed_value(c_seed_value),
      .bound(c_bound), .tdata(c_tdata), .tvalid(c_tvalid), .tready(c_tready),
      .stalled(c_stalled));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rdy;
      logic [7:0] bnd;
      logic       vld;
      logic [7:0] dat;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   gaps;
      int   seen_v;
      logic [7:0] b255, b256;

      reset = 1'b1;
      a_seed_valid = 0; b_seed_valid = 0; c_seed_valid = 0;
      a_seed_value = 0; b_seed_value = 0; c_seed_value = 0;
      a_bound = 0; b_bound = 0; c_bound = 0;
      a_tready = 1; b_tready = 1; c_tready = 1;

      // {tready, bound, expected tvalid, expected tdata}
      tbl[0]  = '{1'b1, 8'h00, 1'b1, 8'hB8};
      tbl[1]  = '{1'b1, 8'h00, 1'b1, 8'h5C};
      tbl[2]  = '{1'b1, 8'h00, 1'b1, 8'h2E};
      tbl[3]  = '{1'b1, 8'h00, 1'b1, 8'h17};
      tbl[4]  = '{1'b1, 8'h00, 1'b1, 8'hB3};
      tbl[5]  = '{1'b0, 8'h00, 1'b1, 8'hB3};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'hB3};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'hB3};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 8'hB3};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'hB3};
      tbl[10] = '{1'b1, 8'h00, 1'b1, 8'hE1};
      tbl[11] = '{1'b1, 8'h00, 1'b1, 8'hC8};
      tbl[12] = '{1'b1, 8'h40, 1'b0, 8'h00};
      tbl[13] = '{1'b1, 8'h40, 1'b1, 8'h32};
      tbl[14] = '{1'b0, 8'h40, 1'b1, 8'h32};
      tbl[15] = '{1'b0, 8'h10, 1'b1, 8'h32};
      tbl[16] = '{1'b1, 8'h10, 1'b0, 8'h00};
      tbl[17] = '{1'b1, 8'h00, 1'b1, 8'hB4};
      tbl[18] = '{1'b1, 8'h00, 1'b1, 8'h5A};

      // Reset values
      do_reset();
      chk("rst a_tvalid", a_tvalid, 0);
      chk("rst a_tdata", a_tdata, 0);
      chk("rst a_stalled", a_stalled, 0);
      chk("rst b_tvalid", b_tvalid, 0);
      chk("rst c_stalled", c_stalled, 0);

      // Stream, backpressure and mid-stream bound changes
      for (int i = 0; i < 19; i++) begin
         a_tready = tbl[i].rdy;
         a_bound  = tbl[i].bnd;
         tick();
         chk($sformatf("tbl%0d tvalid", i), a_tvalid, tbl[i].vld);
         if (tbl[i].vld)
            chk($sformatf("tbl%0d tdata", i), a_tdata, tbl[i].dat);
      end

      // Period 255
      a_tready = 1; a_bound = 0;
      do_reset();
      gaps = 0; b255 = 0; b256 = 0;
      for (int k = 1; k <= 256; k++) begin
         tick();
         if (!a_tvalid) gaps++;
         if (k == 255) b255 = a_tdata;
         if (k == 256) b256 = a_tdata;
      end
      chk("period gaps", gaps, 0);
      chk("period beat255", b255, 8'h01);
      chk("period beat256", b256, 8'hB8);

      // Exclusion of 0x80
      do_reset();
      tick(); chk("excl c1 tvalid", b_tvalid, 0);
      tick(); chk("excl c2 tvalid", b_tvalid, 1); chk("excl c2 tdata", b_tdata, 8'h40);
      tick(); chk("excl c3 tdata", b_tdata, 8'h20);

      // Bound 0x20 from reset
      a_bound = 8'h20;
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("bound c%0d tvalid", k), a_tvalid, 0);
      end
      tick(); chk("bound c4 tvalid", a_tvalid, 1); chk("bound c4 tdata", a_tdata, 8'h17);

      // Reseed while a beat is held
      a_bound = 0; a_tready = 1;
      do_reset();
      tick(); tick();
      chk("hold pre tdata", a_tdata, 8'h5C);
      a_tready = 0; a_seed_valid = 1; a_seed_value = 8'h01;
      tick(); chk("hold seed tvalid", a_tvalid, 1); chk("hold seed tdata", a_tdata, 8'h5C);
      a_seed_valid = 0;
      tick(); chk("hold wait tdata", a_tdata, 8'h5C);
      a_tready = 1;
      tick(); chk("hold new1 tvalid", a_tvalid, 1); chk("hold new1 tdata", a_tdata, 8'hB8);
      tick(); chk("hold new2 tdata", a_tdata, 8'h5C);

      // Reseed with zero on an accepted beat -> restart from SEED=63
      c_bound = 0; c_tready = 1;
      do_reset();
      tick(); chk("rs0 c1", c_tdata, 8'hA7);
      tick(); chk("rs0 c2", c_tdata, 8'hEB);
      tick(); chk("rs0 c3", c_tdata, 8'hCD);
      c_seed_valid = 1; c_seed_value = 8'h00;
      tick(); chk("rs0 bubble tvalid", c_tvalid, 0);
      c_seed_valid = 0;
      tick(); chk("rs0 r1 tvalid", c_tvalid, 1); chk("rs0 r1 tdata", c_tdata, 8'hA7);
      tick(); chk("rs0 r2 tdata", c_tdata, 8'hEB);

      // Unreachable bound -> stall after exactly REJECT_LIMIT rejects
      c_bound = 8'h01; a_bound = 0; a_tready = 1;
      do_reset();
      seen_v = 0;
      for (int k = 1; k <= 1023; k++) begin
         tick();
         if (c_tvalid) seen_v++;
      end
      chk("stall 1023", c_stalled, 0);
      tick(); chk("stall 1024", c_stalled, 1);
      for (int k = 0; k < 5; k++) begin
         tick();
         if (c_tvalid) seen_v++;
      end
      chk("stall sat", c_stalled, 1);
      chk("stall no beats", seen_v, 0);

      // Asynchronous reset mid-cycle
      chk("arst pre a_tvalid", a_tvalid, 1);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("arst a_tvalid", a_tvalid, 0);
      chk("arst a_tdata", a_tdata, 0);
      chk("arst c_stalled", c_stalled, 0);
      tick();
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
